prime_query_master: RTL and testbench

Initiator for the nearest-prime query handshake (`give_valid`/`Intake` out, `out_valid`/`UpPrime`/`LowPrime` in). On a `start` pulse it sweeps a configurable range of `Intake` values and issues one query per value. It independently checks each returned prime pair by trial division and keeps pass/fail statistics. It sits beside the nearest-prime finder as its driver in the lab bench and as a self-checking harness on the board.

---
 rtl/prime_query_master.sv | 217 +++++++++++++++++++++
 tb/tb_prime_query_master.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/prime_query_master.sv
// prime_query_master: drives the nearest-prime query handshake over a range of
// Intake values. Each returned UpPrime/LowPrime pair is checked by trial
// division, and pass/fail statistics are kept.
//
// Ports
//   clk, reset            clock, asynchronous active-high reset
//   start                 begins a sweep; only sampled in IDLE/DONE
//   give_valid, Intake    query strobe (one cycle) and query value
//   UpPrime, LowPrime     responder result pair
//   out_valid             responder result valid (level)
//   busy, done            sweep in progress / sweep finished
//   pass_cnt, fail_cnt    saturating per-query statistics
//   first_fail            Intake of the first failing query, 0 if none
//   timeout_err           sticky, set when any query times out
//
// Optional feature: define PQM_GAP_CHECK_EN to also prove that no prime lies
// strictly between LowPrime and UpPrime (other than Intake itself).
module prime_query_master #(
    parameter int unsigned START   = 3,
    parameter int unsigned STOP    = 9972,
    parameter int unsigned STEP    = 1,
    parameter int unsigned TIMEOUT = 4096
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    output logic        give_valid,
    output logic [13:0] Intake,
    input  logic [13:0] UpPrime,
    input  logic [13:0] LowPrime,
    input  logic        out_valid,
    output logic        busy,
    output logic        done,
    output logic [13:0] pass_cnt,
    output logic [13:0] fail_cnt,
    output logic [13:0] first_fail,
    output logic        timeout_err
);

    localparam int unsigned VW = 14;
    localparam int unsigned CW = 15;
    localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] MAX_PRIME = CW'(9973);
    localparam logic [VW-1:0] CNT_MAX   = '1;

    typedef enum logic [3:0] {
        IDLE, DRAIN, ISSUE, WAIT, CHK_UP, CHK_LOW, CHK_GAP, NEXT, DONE
    } state_t;

    state_t          state_q;
    logic [CW-1:0]   cur_q;
    logic [VW-1:0]   up_q, low_q;
    logic [CW-1:0]   div_q;
    logic [TW-1:0]   timer_q;
    logic            fail_q;
    logic            gv_q, busy_q, done_q, tout_q;
    logic [VW-1:0]   intake_q, pass_q, failc_q, ffail_q;
`ifdef PQM_GAP_CHECK_EN
    logic [CW-1:0]   gap_n_q;
`endif

    logic [CW-1:0]   up_ext_c, low_ext_c, chk_n_c, chk_rem_c, div_sq_c, next_cur_c;

    assign up_ext_c   = {1'b0, up_q};
    assign low_ext_c  = {1'b0, low_q};
    assign div_sq_c   = div_q * div_q;
    assign next_cur_c = cur_q + CW'(STEP);

    // One shared divider: the operand follows whichever check is active.
    always_comb begin
        chk_n_c = up_ext_c;
        if (state_q == CHK_LOW) chk_n_c = low_ext_c;
`ifdef PQM_GAP_CHECK_EN
        if (state_q == CHK_GAP) chk_n_c = gap_n_q;
`endif
        chk_rem_c = chk_n_c % div_q;
    end

    // Sweep sequencer, checker and statistics.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            cur_q    <= '0;
            up_q     <= '0;
            low_q    <= '0;
            div_q    <= CW'(2);
            timer_q  <= '0;
            fail_q   <= 1'b0;
            gv_q     <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            tout_q   <= 1'b0;
            intake_q <= '0;
            pass_q   <= '0;
            failc_q  <= '0;
            ffail_q  <= '0;
`ifdef PQM_GAP_CHECK_EN
            gap_n_q  <= '0;
`endif
        end else begin
            gv_q <= 1'b0;
            case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        pass_q  <= '0;
                        failc_q <= '0;
                        ffail_q <= '0;
                        tout_q  <= 1'b0;
                        cur_q   <= CW'(START);
                        busy_q  <= 1'b1;
                        done_q  <= 1'b0;
                        state_q <= DRAIN;
                    end
                end
                // Responder must be back to idle before the next strobe.
                DRAIN: begin
                    if (!out_valid) begin
                        intake_q <= VW'(cur_q);
                        gv_q     <= 1'b1;
                        state_q  <= ISSUE;
                    end
                end
                ISSUE: begin
                    timer_q <= '0;
                    fail_q  <= 1'b0;
                    state_q <= WAIT;
                end
                WAIT: begin
                    if (out_valid) begin
                        up_q    <= UpPrime;
                        low_q   <= LowPrime;
                        div_q   <= CW'(2);
                        state_q <= CHK_UP;
                    end else if (timer_q == TW'(TIMEOUT - 1)) begin
                        tout_q  <= 1'b1;
                        fail_q  <= 1'b1;
                        state_q <= NEXT;
                    end else begin
                        timer_q <= timer_q + TW'(1);
                    end
                end
                // Square test first so that small primes (d == n) pass.
                CHK_UP: begin
                    if (up_ext_c <= cur_q || up_ext_c > MAX_PRIME || (div_sq_c <= chk_n_c && chk_rem_c == '0)) begin
                        fail_q  <= 1'b1;
                        state_q <= NEXT;
                    end else if (div_sq_c > chk_n_c) begin
                        div_q   <= CW'(2);
                        state_q <= CHK_LOW;
                    end else begin
                        div_q   <= div_q + CW'(1);
                    end
                end
                CHK_LOW: begin
                    if (low_ext_c >= cur_q || low_ext_c < CW'(2) || (div_sq_c <= chk_n_c && chk_rem_c == '0)) begin
                        fail_q  <= 1'b1;
                        state_q <= NEXT;
                    end else if (div_sq_c > chk_n_c) begin
`ifdef PQM_GAP_CHECK_EN
                        div_q   <= CW'(2);
                        gap_n_q <= low_ext_c + CW'(1);
                        state_q <= CHK_GAP;
`else
                        state_q <= NEXT;
`endif
                    end else begin
                        div_q   <= div_q + CW'(1);
                    end
                end
`ifdef PQM_GAP_CHECK_EN
                // Every candidate strictly inside the gap, except the query, must be composite.
                CHK_GAP: begin
                    if (gap_n_q >= up_ext_c) begin
                        state_q <= NEXT;
                    end else if (gap_n_q == cur_q || (div_sq_c <= chk_n_c && chk_rem_c == '0)) begin
                        gap_n_q <= gap_n_q + CW'(1);
                        div_q   <= CW'(2);
                    end else if (div_sq_c > chk_n_c) begin
                        fail_q  <= 1'b1;
                        state_q <= NEXT;
                    end else begin
                        div_q   <= div_q + CW'(1);
                    end
                end
`endif
                NEXT: begin
                    if (fail_q) begin
                        if (failc_q != CNT_MAX) failc_q <= failc_q + VW'(1);
                        // A saturating counter never returns to zero, so zero means first fail.
                        if (failc_q == '0) ffail_q <= VW'(cur_q);
                    end else if (pass_q != CNT_MAX) begin
                        pass_q <= pass_q + VW'(1);
                    end
                    if (next_cur_c > CW'(STOP)) begin
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= DONE;
                    end else begin
                        cur_q   <= next_cur_c;
                        state_q <= DRAIN;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign give_valid  = gv_q;
    assign Intake      = intake_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign pass_cnt    = pass_q;
    assign fail_cnt    = failc_q;
    assign first_fail  = ffail_q;
    assign timeout_err = tout_q;

endmodule

// File: tb/tb_prime_query_master.sv
// Testbench for prime_query_master: three instances (single query at 10 with a
// programmable stub responder, single query at 3, and a 9960..9972 sweep) driven
// by behavioural nearest-prime responders.
module tb_prime_query_master;

    logic clk, reset;
    int   errors, checks;

    // Instance a: START=STOP=10, TIMEOUT=16, stub responder
    logic        a_start, a_gv, a_ov, a_busy, a_done, a_to, a_stub_on;
    logic [13:0] a_intake, a_up, a_low, a_pass, a_fail, a_ff, a_stub_up, a_stub_low;
    // Instance b: START=STOP=3, model responder
    logic        b_start, b_gv, b_ov, b_busy, b_done, b_to;
    logic [13:0] b_intake, b_up, b_low, b_pass, b_fail, b_ff;
    // Instance c: START=9960, STOP=9972, model responder
    logic        c_start, c_gv, c_ov, c_busy, c_done, c_to;
    logic [13:0] c_intake, c_up, c_low, c_pass, c_fail, c_ff;

    prime_query_master #(.START(10), .STOP(10), .STEP(1), .TIMEOUT(16)) u_a (
        .clk(clk), .reset(reset), .start(a_start), .give_valid(a_gv), .Intake(a_intake),
        .UpPrime(a_up), .LowPrime(a_low), .out_valid(a_ov), .busy(a_busy), .done(a_done),
        .pass_cnt(a_pass), .fail_cnt(a_fail), .first_fail(a_ff), .timeout_err(a_to));

    prime_query_master #(.START(3), .STOP(3), .STEP(1), .TIMEOUT(4096)) u_b (
        .clk(clk), .reset(reset), .start(b_start), .give_valid(b_gv), .Intake(b_intake),
        .UpPrime(b_up), .LowPrime(b_low), .out_valid(b_ov), .busy(b_busy), .done(b_done),
        .pass_cnt(b_pass), .fail_cnt(b_fail), .first_fail(b_ff), .timeout_err(b_to));

    prime_query_master #(.START(9960), .STOP(9972), .STEP(1), .TIMEOUT(4096)) u_c (
        .clk(clk), .reset(reset), .start(c_start), .give_valid(c_gv), .Intake(c_intake),
        .UpPrime(c_up), .LowPrime(c_low), .out_valid(c_ov), .busy(c_busy), .done(c_done),
        .pass_cnt(c_pass), .fail_cnt(c_fail), .first_fail(c_ff), .timeout_err(c_to));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic bit is_prime(input int n);
        if (n < 2) return 1'b0;
        for (int d = 2; d * d <= n; d++) if (n % d == 0) return 1'b0;
        return 1'b1;
    endfunction

    function automatic int next_prime(input int n);
        int p = n + 1;
        while (!is_prime(p)) p++;
        return p;
    endfunction

    function automatic int prev_prime(input int n);
        int p = n - 1;
        while (p >= 2 && !is_prime(p)) p--;
        return p;
    endfunction

    // Stub responder for instance a: answers two cycles after the strobe, holds valid 3 cycles
    initial begin
        a_ov = 1'b0; a_up = '0; a_low = '0;
        forever begin
            @(negedge clk);
            if (a_gv && a_stub_on) begin
                repeat (2) @(negedge clk);
                a_up = a_stub_up; a_low = a_stub_low; a_ov = 1'b1;
                repeat (3) @(negedge clk);
                a_ov = 1'b0;
            end
        end
    end

    // Nearest-prime model responder for instance b
    initial begin
        int q;
        b_ov = 1'b0; b_up = '0; b_low = '0;
        forever begin
            @(negedge clk);
            if (b_gv) begin
                q = int'(b_intake);
                repeat (2) @(negedge clk);
                b_up = 14'(next_prime(q)); b_low = 14'(prev_prime(q)); b_ov = 1'b1;
                repeat (2) @(negedge clk);
                b_ov = 1'b0;
            end
        end
    end

    // Nearest-prime model responder for instance c
    initial begin
        int q;
        c_ov = 1'b0; c_up = '0; c_low = '0;
        forever begin
            @(negedge clk);
            if (c_gv) begin
                q = int'(c_intake);
                repeat (2) @(negedge clk);
                c_up = 14'(next_prime(q)); c_low = 14'(prev_prime(q)); c_ov = 1'b1;
                repeat (2) @(negedge clk);
                c_ov = 1'b0;
            end
        end
    end

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic pulse_a_start();
        @(negedge clk); a_start = 1'b1;
        @(negedge clk); a_start = 1'b0;
    endtask

    task automatic wait_done_a(input int limit, output int gvs);
        gvs = 0;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (a_gv) gvs++;
            if (a_done) break;
        end
        checks++;
        if (a_done !== 1'b1) begin errors++; $display("FAIL a_done got=%b want=1", a_done); end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        checks += 8;
        if (a_gv !== 1'b0)      begin errors++; $display("FAIL rst_give_valid got=%b want=0", a_gv); end
        if (a_intake !== 14'd0) begin errors++; $display("FAIL rst_intake got=%0d want=0", a_intake); end
        if (a_busy !== 1'b0)    begin errors++; $display("FAIL rst_busy got=%b want=0", a_busy); end
        if (a_done !== 1'b0)    begin errors++; $display("FAIL rst_done got=%b want=0", a_done); end
        if (a_pass !== 14'd0)   begin errors++; $display("FAIL rst_pass got=%0d want=0", a_pass); end
        if (a_fail !== 14'd0)   begin errors++; $display("FAIL rst_fail got=%0d want=0", a_fail); end
        if (a_ff !== 14'd0)     begin errors++; $display("FAIL rst_first_fail got=%0d want=0", a_ff); end
        if (a_to !== 1'b0)      begin errors++; $display("FAIL rst_timeout got=%b want=0", a_to); end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_single_pass();
        int gvs;
        do_reset();
        a_stub_up = 14'd11; a_stub_low = 14'd7; a_stub_on = 1'b1;
        pulse_a_start();
        checks++;
        if (a_busy !== 1'b1) begin errors++; $display("FAIL busy_t1 got=%b want=1", a_busy); end
        @(negedge clk);
        checks += 2;
        if (a_gv !== 1'b1)       begin errors++; $display("FAIL give_valid_t2 got=%b want=1", a_gv); end
        if (a_intake !== 14'd10) begin errors++; $display("FAIL intake_t2 got=%0d want=10", a_intake); end
        wait_done_a(200, gvs);
        checks += 6;
        if (gvs !== 0)          begin errors++; $display("FAIL extra_give_valid got=%0d want=0", gvs); end
        if (a_pass !== 14'd1)   begin errors++; $display("FAIL single_pass got=%0d want=1", a_pass); end
        if (a_fail !== 14'd0)   begin errors++; $display("FAIL single_fail got=%0d want=0", a_fail); end
        if (a_busy !== 1'b0)    begin errors++; $display("FAIL single_busy got=%b want=0", a_busy); end
        if (a_ff !== 14'd0)     begin errors++; $display("FAIL single_first_fail got=%0d want=0", a_ff); end
        if (a_to !== 1'b0)      begin errors++; $display("FAIL single_timeout got=%b want=0", a_to); end
    endtask

    task automatic test_restart();
        int gvs;
        pulse_a_start();
        checks += 3;
        if (a_done !== 1'b0)  begin errors++; $display("FAIL restart_done got=%b want=0", a_done); end
        if (a_busy !== 1'b1)  begin errors++; $display("FAIL restart_busy got=%b want=1", a_busy); end
        if (a_pass !== 14'd0) begin errors++; $display("FAIL restart_clear got=%0d want=0", a_pass); end
        wait_done_a(200, gvs);
        checks++;
        if (a_pass !== 14'd1) begin errors++; $display("FAIL restart_pass got=%0d want=1", a_pass); end
    endtask

    // Stub pairs for Intake 10 with hand-derived verdicts (without / with gap check)
    task automatic test_check_table();
        int t_up[11]  = '{11, 12, 13, 11, 11, 10, 11, 25, 11, 9973, 10007};
        int t_low[11] = '{ 7,  7,  7,  9,  1,  7, 10,  7,  5,    7,     7};
        int t_ng[11]  = '{ 1,  0,  1,  0,  0,  0,  0,  0,  1,    1,     0};
        int t_g[11]   = '{ 1,  0,  0,  0,  0,  0,  0,  0,  0,    0,     0};
        int gvs, ep;
        for (int i = 0; i < 11; i++) begin
            do_reset();
            a_stub_up = 14'(t_up[i]); a_stub_low = 14'(t_low[i]); a_stub_on = 1'b1;
            pulse_a_start();
            wait_done_a(400, gvs);
`ifdef PQM_GAP_CHECK_EN
            ep = t_g[i];
`else
            ep = t_ng[i];
`endif
            checks += 3;
            if (a_pass !== 14'(ep))
                begin errors++; $display("FAIL tbl%0d_pass up=%0d low=%0d got=%0d want=%0d", i, t_up[i], t_low[i], a_pass, ep); end
            if (a_fail !== 14'(1 - ep))
                begin errors++; $display("FAIL tbl%0d_fail up=%0d low=%0d got=%0d want=%0d", i, t_up[i], t_low[i], a_fail, 1 - ep); end
            if (a_ff !== 14'(ep != 0 ? 0 : 10))
                begin errors++; $display("FAIL tbl%0d_first_fail got=%0d want=%0d", i, a_ff, ep != 0 ? 0 : 10); end
        end
    endtask

    task automatic test_timeout();
        int n, gvs;
        bit seen;
        do_reset();
        a_stub_on = 1'b0;
        pulse_a_start();
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (a_gv) begin seen = 1'b1; break; end
        end
        checks++;
        if (seen !== 1'b1) begin errors++; $display("FAIL to_strobe got=%b want=1", seen); end
        n = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (a_to) break;
            n++;
        end
        checks++;
        if (n !== 16) begin errors++; $display("FAIL to_wait_cycles got=%0d want=16", n); end
        wait_done_a(50, gvs);
        checks += 4;
        if (a_to !== 1'b1)     begin errors++; $display("FAIL to_flag got=%b want=1", a_to); end
        if (a_fail !== 14'd1)  begin errors++; $display("FAIL to_fail got=%0d want=1", a_fail); end
        if (a_pass !== 14'd0)  begin errors++; $display("FAIL to_pass got=%0d want=0", a_pass); end
        if (a_ff !== 14'd10)   begin errors++; $display("FAIL to_first_fail got=%0d want=10", a_ff); end
    endtask

    task automatic test_hold();
        bit seen;
        do_reset();
        @(negedge clk); b_start = 1'b1;
        @(negedge clk); b_start = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (b_gv) seen = 1'b1;
            if (b_done) break;
            if (seen) begin
                checks++;
                if (b_intake !== 14'd3) begin errors++; $display("FAIL hold_intake cyc=%0d got=%0d want=3", i, b_intake); end
            end
        end
        checks += 3;
        if (b_done !== 1'b1)  begin errors++; $display("FAIL hold_done got=%b want=1", b_done); end
        if (b_pass !== 14'd1) begin errors++; $display("FAIL hold_pass got=%0d want=1", b_pass); end
        if (b_fail !== 14'd0) begin errors++; $display("FAIL hold_fail got=%0d want=0", b_fail); end
    endtask

    task automatic test_sweep();
        int gvs;
        do_reset();
        @(negedge clk); c_start = 1'b1;
        @(negedge clk); c_start = 1'b0;
        gvs = 0;
        for (int i = 0; i < 20000; i++) begin
            @(negedge clk);
            if (c_gv) gvs++;
            if (c_done) break;
        end
        checks += 5;
        if (c_done !== 1'b1)   begin errors++; $display("FAIL sweep_done got=%b want=1", c_done); end
        if (gvs !== 13)        begin errors++; $display("FAIL sweep_strobes got=%0d want=13", gvs); end
        if (c_pass !== 14'd13) begin errors++; $display("FAIL sweep_pass got=%0d want=13", c_pass); end
        if (c_fail !== 14'd0)  begin errors++; $display("FAIL sweep_fail got=%0d want=0", c_fail); end
        if (c_ff !== 14'd0)    begin errors++; $display("FAIL sweep_first_fail got=%0d want=0", c_ff); end
    endtask

    task automatic test_reset_mid_wait();
        bit seen;
        do_reset();
        @(negedge clk); c_start = 1'b1;
        @(negedge clk); c_start = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (c_gv) begin seen = 1'b1; break; end
        end
        checks++;
        if (seen !== 1'b1) begin errors++; $display("FAIL mid_strobe got=%b want=1", seen); end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        checks += 6;
        if (c_busy !== 1'b0)    begin errors++; $display("FAIL mid_busy got=%b want=0", c_busy); end
        if (c_gv !== 1'b0)      begin errors++; $display("FAIL mid_give_valid got=%b want=0", c_gv); end
        if (c_intake !== 14'd0) begin errors++; $display("FAIL mid_intake got=%0d want=0", c_intake); end
        if (c_pass !== 14'd0)   begin errors++; $display("FAIL mid_pass got=%0d want=0", c_pass); end
        if (c_done !== 1'b0)    begin errors++; $display("FAIL mid_done got=%b want=0", c_done); end
        if (c_to !== 1'b0)      begin errors++; $display("FAIL mid_timeout got=%b want=0", c_to); end
        reset = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            checks++;
            if (c_busy !== 1'b0 || c_gv !== 1'b0)
                begin errors++; $display("FAIL mid_idle cyc=%0d busy=%b gv=%b want=0/0", i, c_busy, c_gv); end
        end
        @(negedge clk); c_start = 1'b1;
        @(negedge clk); c_start = 1'b0;
        checks++;
        if (c_busy !== 1'b1) begin errors++; $display("FAIL mid_restart_busy got=%b want=1", c_busy); end
    endtask

    initial begin
        errors = 0; checks = 0;
        reset = 1'b1;
        a_start = 1'b0; b_start = 1'b0; c_start = 1'b0;
        a_stub_on = 1'b0; a_stub_up = '0; a_stub_low = '0;
        test_reset();
        test_single_pass();
        test_restart();
        test_check_table();
        test_timeout();
        test_hold();
        test_sweep();
        test_reset_mid_wait();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
